// File: rtl/saa1099_i2s_out.sv
// SAA1099 stereo mixer output -> Philips I2S serialiser (64 BCLK per frame, 32-bit slots).
// Optional boxcar decimation of the input samples is enabled by defining SAA_I2S_AVG_EN.
module saa1099_i2s_out #(
  parameter int BCLK_HALF = 4,
  parameter int AVG_LOG2  = 3
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       ce,
  input  logic [7:0] in_l,
  input  logic [7:0] in_r,
  input  logic       mute,
  output logic       i2s_bclk,
  output logic       i2s_lrclk,
  output logic       i2s_data,
  output logic       frame_strobe
);
  localparam logic [7:0] DIV_LAST = 8'(BCLK_HALF - 1);

  if (BCLK_HALF < 1 || BCLK_HALF > 255 || AVG_LOG2 < 1 || AVG_LOG2 > 6) begin : g_param_chk
    $error("saa1099_i2s_out: parameter out of range");
  end

  function automatic logic [15:0] to_s16(input logic [7:0] x);
    return {~x[7], x[6:0], 8'h00};
  endfunction

  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        bclk_q, bclk_d, lrclk_q, lrclk_d, data_q, data_d;
  logic        strobe_q, strobe_d, mute_q, mute_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d, bit_nxt;
  logic [15:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [15:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic [15:0] word;
  logic [4:0]  slot;
  logic [3:0]  bit_sel;
  logic        fall;

`ifdef SAA_I2S_AVG_EN
  localparam int ACC_W = 8 + AVG_LOG2;
  logic [ACC_W-1:0]    acc_l_q, acc_l_d, acc_r_q, acc_r_d, sum_l, sum_r;
  logic [AVG_LOG2-1:0] avg_cnt_q, avg_cnt_d;

  // Sum of 2^AVG_LOG2 8-bit samples fits ACC_W exactly, so the mean is the top 8 bits.
  always_comb begin
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    avg_cnt_d = avg_cnt_q;
    sum_l     = acc_l_q + ACC_W'(in_l);
    sum_r     = acc_r_q + ACC_W'(in_r);
    if (ce) begin
      if (&avg_cnt_q) begin
        hold_l_d  = to_s16(8'(sum_l >> AVG_LOG2));
        hold_r_d  = to_s16(8'(sum_r >> AVG_LOG2));
        acc_l_d   = '0;
        acc_r_d   = '0;
        avg_cnt_d = '0;
      end else begin
        acc_l_d   = sum_l;
        acc_r_d   = sum_r;
        avg_cnt_d = avg_cnt_q + AVG_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      avg_cnt_q <= '0;
    end else begin
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      avg_cnt_q <= avg_cnt_d;
    end
  end
`else
  always_comb begin
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    if (ce) begin
      hold_l_d = to_s16(in_l);
      hold_r_d = to_s16(in_r);
    end
  end
`endif

  always_comb begin
    div_cnt_d = div_cnt_q + 8'd1;
    bclk_d    = bclk_q;
    fall      = 1'b0;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
      fall      = bclk_q;
    end
    bit_nxt   = bit_cnt_q + 6'd1;
    slot      = bit_nxt[4:0];
    bit_sel   = 4'(5'd16 - slot);
    word      = bit_nxt[5] ? shift_r_q : shift_l_q;
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    data_d    = data_q;
    strobe_d  = 1'b0;
    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    mute_d    = mute_q;
    // Everything serial moves on the BCLK falling edge so the codec samples mid-bit.
    if (fall) begin
      bit_cnt_d = bit_nxt;
      lrclk_d   = bit_nxt[5];
      if (bit_nxt == 6'd0) begin
        mute_d    = mute;
        shift_l_d = mute ? 16'h0 : hold_l_q;
        shift_r_d = mute ? 16'h0 : hold_r_q;
        strobe_d  = 1'b1;
      end
      data_d = (slot >= 5'd1 && slot <= 5'd16) ? (word[bit_sel] & ~mute_d) : 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= '0;
      lrclk_q   <= 1'b0;
      data_q    <= 1'b0;
      strobe_q  <= 1'b0;
      mute_q    <= 1'b0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      shift_l_q <= '0;
      shift_r_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      lrclk_q   <= lrclk_d;
      data_q    <= data_d;
      strobe_q  <= strobe_d;
      mute_q    <= mute_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
      shift_l_q <= shift_l_d;
      shift_r_q <= shift_r_d;
    end
  end

  assign i2s_bclk     = bclk_q;
  assign i2s_lrclk    = lrclk_q;
  assign i2s_data     = data_q;
  assign frame_strobe = strobe_q;
endmodule

// File: tb/tb_saa1099_i2s_out.sv
// Bench for saa1099_i2s_out: decodes the I2S stream and scores words against a frame queue.
module tb_saa1099_i2s_out;
  localparam int BH = 4;
  localparam int AL = 3;
  typedef struct { logic [15:0] l; logic [15:0] r; } frame_t;

  logic       clk_sys = 1'b0, rst_n = 1'b0, ce = 1'b0, mute = 1'b0;
  logic [7:0] in_l = 8'h80, in_r = 8'h80;
  logic       i2s_bclk, i2s_lrclk, i2s_data, frame_strobe;
  int total = 0, bad = 0, cyc = 0, ce_div = 4;
  bit ce_en = 1'b0, alt_en = 1'b0;

  saa1099_i2s_out #(.BCLK_HALF(BH), .AVG_LOG2(AL)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .ce(ce), .in_l(in_l), .in_r(in_r), .mute(mute),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_data(i2s_data), .frame_strobe(frame_strobe));

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    ce = ce_en && (cyc % ce_div == 0);
    if (ce && alt_en) in_l = ~in_l;
  end

  function automatic logic [15:0] conv(input logic [7:0] x);
    return {~x[7], x[6:0], 8'h00};
  endfunction

  // Reference hold registers; s_* snapshot the pre-edge values a frame latch would see.
  logic [15:0] m_hl = 16'h0, m_hr = 16'h0, s_hl = 16'h0, s_hr = 16'h0;
  logic        s_mute = 1'b0, m_ml = 1'b0;
`ifdef SAA_I2S_AVG_EN
  int m_al = 0, m_ar = 0, m_ac = 0;
`endif
  always @(posedge clk_sys) begin
    s_hl <= m_hl; s_hr <= m_hr; s_mute <= mute;
    if (!rst_n) begin
      m_hl <= 16'h0; m_hr <= 16'h0;
`ifdef SAA_I2S_AVG_EN
      m_al <= 0; m_ar <= 0; m_ac <= 0;
`endif
    end else if (ce) begin
`ifdef SAA_I2S_AVG_EN
      if (m_ac == (1 << AL) - 1) begin
        m_hl <= conv(8'((m_al + int'(in_l)) / (1 << AL)));
        m_hr <= conv(8'((m_ar + int'(in_r)) / (1 << AL)));
        m_al <= 0; m_ar <= 0; m_ac <= 0;
      end else begin
        m_al <= m_al + int'(in_l); m_ar <= m_ar + int'(in_r); m_ac <= m_ac + 1;
      end
`else
      m_hl <= conv(in_l); m_hr <= conv(in_r);
`endif
    end
  end

  // Receiver: on each BCLK rise, slot position 0 follows an LRCLK change.
  frame_t q[$];
  frame_t cur = '{16'h0, 16'h0};
  int pos = -1, l_cnt = 0, r_cnt = 0;
  logic last_lr = 1'b0, prev_bclk = 1'b0, pad_err = 1'b0;
  logic [15:0] word = 16'h0, last_l = 16'h0, last_r = 16'h0;
  always @(negedge clk_sys) begin
    if (!rst_n) begin
      m_ml = 1'b0; pos = -1; last_lr = 1'b0; prev_bclk = 1'b0; pad_err = 1'b0; word = 16'h0;
    end else begin
      if (frame_strobe) begin
        m_ml = s_mute;
        if (m_ml) q.push_back('{16'h0, 16'h0});
        else      q.push_back('{s_hl, s_hr});
      end
      if (i2s_bclk && !prev_bclk) begin
        pos = (i2s_lrclk != last_lr) ? 0 : pos + 1;
        last_lr = i2s_lrclk;
        if (pos >= 1 && pos <= 16) begin
          word = {word[14:0], i2s_data};
          if (pos == 16) begin
            total++;
            if (!i2s_lrclk) begin
              if (q.size() == 0) begin
                bad++; $display("FAIL sb_left: got %h with no expected frame queued", word);
              end else begin
                cur = q.pop_front();
                if (word !== cur.l) begin bad++; $display("FAIL sb_left: got %h exp %h", word, cur.l); end
              end
              last_l = word; l_cnt++;
            end else begin
              if (word !== cur.r) begin bad++; $display("FAIL sb_right: got %h exp %h", word, cur.r); end
              last_r = word; r_cnt++;
            end
          end
        end else begin
          pad_err = (pos == 0) ? i2s_data : (pad_err | i2s_data);
          if (pos == 31) begin
            total++;
            if (pad_err !== 1'b0) begin bad++; $display("FAIL pad: slot lr=%0d got nonzero exp 0", i2s_lrclk); end
          end
          if (pos == 32) begin
            total++; bad++; $display("FAIL slot_len: got >32 bits exp 32");
          end
        end
      end
      prev_bclk = i2s_bclk;
    end
  end

  task automatic wait_words(input bit right, input int n);
    int start, lim;
    start = right ? r_cnt : l_cnt;
    lim = cyc + n * 600 + 600;
    while ((right ? r_cnt : l_cnt) < start + n && cyc < lim) @(posedge clk_sys);
    if ((right ? r_cnt : l_cnt) < start + n) begin
      total++; bad++; $display("FAIL timeout: got fewer than %0d words (right=%0d)", n, right);
    end
  endtask

  // kind: 0 bclk rise, 1 frame_strobe, 2 lrclk toggle, 3 lrclk rise, 4 data high
  task automatic wait_evt(input int kind, output int at);
    logic pb, pl;
    int lim;
    at = -1; lim = cyc + 2000;
    @(negedge clk_sys); pb = i2s_bclk; pl = i2s_lrclk;
    while (at < 0 && cyc < lim) begin
      @(negedge clk_sys);
      case (kind)
        0: if (i2s_bclk && !pb) at = cyc;
        1: if (frame_strobe) at = cyc;
        2: if (i2s_lrclk != pl) at = cyc;
        3: if (i2s_lrclk && !pl) at = cyc;
        default: if (i2s_data) at = cyc;
      endcase
      pb = i2s_bclk; pl = i2s_lrclk;
    end
  endtask

  task automatic test_reset();
    @(negedge clk_sys); rst_n = 1'b0;
    @(negedge clk_sys);
    total++;
    if ({i2s_bclk, i2s_lrclk, i2s_data, frame_strobe} !== 4'b0) begin
      bad++; $display("FAIL reset_next_edge: got %b exp 0000", {i2s_bclk, i2s_lrclk, i2s_data, frame_strobe});
    end
    repeat (4) @(negedge clk_sys);
    total++;
    if ({i2s_bclk, i2s_lrclk, i2s_data, frame_strobe} !== 4'b0) begin
      bad++; $display("FAIL reset_hold: got %b exp 0000", {i2s_bclk, i2s_lrclk, i2s_data, frame_strobe});
    end
    q.delete(); q.push_back('{16'h0, 16'h0});
    rst_n = 1'b1;
    wait_words(1'b1, 1);
    total++;
    if ({last_l, last_r} !== 32'h0) begin bad++; $display("FAIL first_frame: got %h exp 00000000", {last_l, last_r}); end
  endtask

  task automatic test_timing();
    int a, b;
    in_l = 8'h80; in_r = 8'h00;
    wait_evt(0, a); wait_evt(0, b);
    total++; if (b - a != 2 * BH) begin bad++; $display("FAIL bclk_period: got %0d exp %0d", b - a, 2 * BH); end
    wait_evt(1, a); wait_evt(1, b);
    total++; if (b - a != 128 * BH) begin bad++; $display("FAIL frame_period: got %0d exp %0d", b - a, 128 * BH); end
    wait_evt(2, a); wait_evt(2, b);
    total++; if (b - a != 64 * BH) begin bad++; $display("FAIL lrclk_half: got %0d exp %0d", b - a, 64 * BH); end
    wait_words(1'b1, 1);
    wait_evt(3, a); wait_evt(4, b);
    total++; if (b - a != 2 * BH) begin bad++; $display("FAIL lrclk_to_msb: got %0d exp %0d", b - a, 2 * BH); end
  endtask

  task automatic test_full_scale();
    in_l = 8'hFF; in_r = 8'h00;
    wait_words(1'b1, 3);
    total++; if (last_l !== 16'h7F00) begin bad++; $display("FAIL full_left: got %h exp 7f00", last_l); end
    total++; if (last_r !== 16'h8000) begin bad++; $display("FAIL full_right: got %h exp 8000", last_r); end
  endtask

  task automatic test_midframe_step();
    int a;
    in_l = 8'h80; in_r = 8'h80;
    wait_words(1'b1, 3);
    total++; if ({last_l, last_r} !== 32'h0) begin bad++; $display("FAIL silence: got %h exp 00000000", {last_l, last_r}); end
    wait_evt(1, a);
    in_l = 8'h90;
    wait_words(1'b0, 1);
    total++; if (last_l !== 16'h0000) begin bad++; $display("FAIL step_cur_frame: got %h exp 0000", last_l); end
    wait_words(1'b0, 1);
    total++; if (last_l !== 16'h1000) begin bad++; $display("FAIL step_next_frame: got %h exp 1000", last_l); end
  endtask

  task automatic test_mute();
    int a, b;
    in_l = 8'hFF; in_r = 8'h00;
    wait_words(1'b1, 3);
    wait_evt(3, a);
    repeat (8) wait_evt(0, b);
    mute = 1'b1;
    wait_words(1'b1, 1);
    total++; if (last_r !== 16'h8000) begin bad++; $display("FAIL mute_cur_right: got %h exp 8000", last_r); end
    wait_words(1'b1, 1);
    total++; if ({last_l, last_r} !== 32'h0) begin bad++; $display("FAIL mute_next: got %h exp 00000000", {last_l, last_r}); end
    mute = 1'b0;
    wait_words(1'b1, 1);
    total++; if ({last_l, last_r} !== 32'h7F008000) begin bad++; $display("FAIL unmute: got %h exp 7f008000", {last_l, last_r}); end
  endtask

`ifdef SAA_I2S_AVG_EN
  task automatic test_avg();
    int lim;
    in_r = 8'h80; in_l = 8'h00; alt_en = 1'b1;
    wait_words(1'b1, 3);
    total++; if (last_l !== 16'hFF00) begin bad++; $display("FAIL avg_alt_left: got %h exp ff00", last_l); end
    total++; if (last_r !== 16'h0000) begin bad++; $display("FAIL avg_alt_right: got %h exp 0000", last_r); end
    alt_en = 1'b0; in_l = 8'hFF;
    repeat (40) @(negedge clk_sys);
    lim = cyc + 200;
    while (m_ac != 4 && cyc < lim) @(negedge clk_sys);
    in_l = 8'h00; ce_div = 48;
    test_reset();
    wait_words(1'b0, 1);
    total++; if (last_l !== 16'h8000) begin bad++; $display("FAIL avg_fresh_window: got %h exp 8000", last_l); end
    ce_div = 4;
  endtask
`endif

  initial begin
    test_reset();
    ce_en = 1'b1;
    test_timing();
    test_full_scale();
    test_reset();
    test_midframe_step();
    test_mute();
`ifdef SAA_I2S_AVG_EN
    test_avg();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/saa1099_i2s_out.md
Name: saa1099_i2s_out

Overview:
Downstream stage of the SAA1099 sound core. Takes the 8-bit unsigned stereo mixer outputs (out_l/out_r), sampled on the 8 MHz clock enable, and converts them to signed 16-bit. Serialises them as a standard Philips I2S stream (64 BCLK per frame, 32-bit slots) for an external codec/DAC. All logic is in the clk_sys domain; BCLK/LRCLK are generated from clk_sys by an internal divider.

Parameters:
BCLK_HALF, 4, clk_sys cycles per BCLK half-period (legal range 1..255).
AVG_LOG2, 3, log2 of the averaging window in ce ticks (used only with the optional feature; legal range 1..6).

Ports:
clk_sys  in  1  system clock
rst_n  in  1  synchronous reset, active-low
ce  in  1  8 MHz sample strobe, one clk_sys wide
in_l  in  8  left sample from the SAA1099 core, unsigned, 0x80 = silence
in_r  in  8  right sample, unsigned
mute  in  1  forces zero samples, takes effect from the next frame
i2s_bclk  out  1  bit clock
i2s_lrclk  out  1  word select: 0 = left, 1 = right
i2s_data  out  1  serial data, MSB first
frame_strobe  out  1  one clk_sys pulse when a new stereo frame is latched

Behaviour:
- Reset is synchronous, active-low, on clk_sys.
  - Reset values: i2s_bclk=0, i2s_lrclk=0, i2s_data=0, frame_strobe=0.
  - Divider, bit counter, shift registers, hold registers and mute latch all reset to 0.
  - Reset asserted mid-frame aborts the frame immediately; outputs are at reset values on the next clock edge.
- Conversion: s16 = {~x[7], x[6:0], 8'h00}.
  - 0x80 -> 0x0000, 0xFF -> 0x7F00, 0x00 -> 0x8000.
- Hold registers hold_l/hold_r (16 bit): on every ce, load the converted in_l/in_r. Registration latency is 1 clk.
- Divider: div_cnt counts 0..BCLK_HALF-1. At the terminal count it wraps to 0 and i2s_bclk toggles.
  - BCLK period = 2*BCLK_HALF clk_sys.
- Falling edge = the clk where bclk goes 1->0. All of the following happen only on falling edges:
  - bit_cnt (6 bit) increments, wrapping 63->0.
  - i2s_lrclk <= new bit_cnt[5]. LRCLK therefore changes when entering slot bit 0 or 32, one BCLK before the MSB (I2S delay).
  - i2s_data drives slot bit n = bit_cnt[4:0]:
    - n=0: previous slot's padding, value 0.
    - n=1..16: sample bits 15..0.
    - n=17..31: 0.
- Frame latch, on the falling edge entering bit_cnt=0:
  - shift_l <= hold_l and shift_r <= hold_r, or both 0 if the mute latch is set.
  - mute latch <= mute.
  - frame_strobe = 1 for that single clk_sys.
- Simultaneous ce and frame latch: the latch takes the hold value from before the ce update (registered semantics).
- mute changing mid-frame does not affect the current frame.
- Frame length = 128*BCLK_HALF clk_sys cycles. ce rate and frame rate are asynchronous; hold registers decouple them, and intermediate samples are dropped.

Optional Feature:
Macro SAA_I2S_AVG_EN.
- Defined: a per-channel accumulator, width 8+AVG_LOG2, sums raw in_x on each ce, with an avg_cnt of width AVG_LOG2.
  - On the ce where avg_cnt = 2^AVG_LOG2-1: hold_x <= convert((acc+in_x) >> AVG_LOG2), then acc <= 0 and avg_cnt <= 0.
  - Otherwise acc accumulates and hold is unchanged.
  - Reset clears acc and avg_cnt.
  - This acts as a boxcar decimation filter that suppresses tone aliasing.
- Not defined: hold updated on every ce as described in Behaviour; no accumulator logic is present.

Test Plan:
1. Reset: hold rst_n=0 for 5 clks -> bclk, lrclk, data and frame_strobe = 0. First frame after release transmits 0x0000 in both slots.
2. BCLK_HALF=4, free-running -> bclk period 8 clk; frame_strobe every 512 clk; lrclk toggles every 256 clk; lrclk edge precedes the MSB by 8 clk.
3. in_l=0xFF, in_r=0x00 steady, ce every 4 clk -> decoded left word 0x7F00, right word 0x8000; slot bits 17..31 = 0.
4. in_l=in_r=0x80 -> both words 0x0000. Step in_l to 0x90 mid-frame -> current frame unchanged, next frame left = 0x1000.
5. Assert mute at bit_cnt=40 -> current right slot carries data; next frame both 0x0000. Deassert mute -> data resumes one frame later.
6. SAA_I2S_AVG_EN, AVG_LOG2=3, in_l alternating 0x00/0xFF per ce -> hold_l = convert(1020>>3 = 0x7F) = 0xFF00. Assert rst_n=0 mid-window -> acc cleared and the next window starts fresh.
